keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, 1000, clocks each column is driven before its rows are sampled (min 4).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, 4, consecutive identical scan frames needed to accept a press or a release (min 1).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port row  input  4  keypad row lines; 1 = pressed in the driven column; asynchronous to clk.
REQ-006 SHALL have port col  output  3  keypad column drive; one-hot, active-high.
REQ-007 SHALL have port key_code  output  4  code of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-clock pulse when a new key is accepted.
REQ-009 SHALL have port key_held  output  1  high from acceptance until the release is debounced.

Function
REQ-010 SHALL pass row through a 2-flop synchronizer before any use.
REQ-011 SHALL drive col in the sequence 001 -> 010 -> 100 -> 001, advancing every SCAN_DIV clocks.
REQ-012 SHALL sample the synchronized rows on the last clock of each column period; one frame = 3 column periods = 3*SCAN_DIV clocks.
REQ-013 SHALL map (row r, col c) to codes: r0 = 1,2,3; r1 = 4,5,6; r2 = 7,8,9; r3 = 10 (*),0,11 (#).
REQ-014 SHALL classify each frame at its end as NONE (no bits set), SINGLE(code) (exactly one bit set) or MULTI (two or more bits set).
REQ-015 SHALL implement FSM states IDLE, DEBOUNCE, PRESSED and RELEASE.
REQ-016 IDLE: on a SINGLE(k) frame, SHALL latch candidate k, set the frame count to 1 and go to DEBOUNCE; if DEBOUNCE_FRAMES = 1, SHALL accept immediately.
REQ-017 DEBOUNCE: on SINGLE(k) equal to the candidate, SHALL increment the count; on reaching DEBOUNCE_FRAMES, SHALL accept.
REQ-018 DEBOUNCE: on SINGLE of a different key, SHALL restart with that key as candidate at count 1; on NONE or MULTI, SHALL return to IDLE.
REQ-019 On accept, SHALL update key_code to the candidate, pulse key_valid for exactly one clock (the clock after the frame end), set key_held, and go to PRESSED.
REQ-020 PRESSED: SHALL ignore SINGLE and MULTI frames, so no new key_valid is issued until release; on NONE, SHALL go to RELEASE with count 1.
REQ-021 RELEASE: on NONE, SHALL increment the count; on reaching DEBOUNCE_FRAMES, SHALL clear key_held and go to IDLE; on any non-NONE frame, SHALL return to PRESSED.
REQ-022 SHALL hold key_code after release until the next accept.
REQ-023 SHALL saturate frame counters at DEBOUNCE_FRAMES, sized $clog2(DEBOUNCE_FRAMES+1) bits.
REQ-024 SHALL wrap the prescaler from SCAN_DIV-1 to 0 with no lost or extra clock.

Reset
REQ-025 While rst is high at a clock edge, SHALL force col = 001, prescaler = 0, synchronizer flops = 0, state = IDLE, counts = 0, key_code = 0, key_valid = 0 and key_held = 0.
REQ-026 Asserting rst mid-frame or in PRESSED SHALL discard the partial frame and any held key, with no key_valid on reset exit.
REQ-027 The first frame after reset deassertion SHALL start on the column 001 period.

Structure
REQ-028 SHALL place the key code constants (KEY_STAR = 10, KEY_HASH = 11) and the state enum in shared package doorlock_pkg.
REQ-029 SHALL use one sub-module, keypad_sync (2-flop, 4-bit synchronizer); all other logic is in keypad_scan.

Verification (SCAN_DIV = 4, DEBOUNCE_FRAMES = 2, frame = 12 clocks)
REQ-030 Reset: after rst, check col = 001, key_code = 0, key_valid = 0 and key_held = 0; check col steps to 010 after 4 clocks.
REQ-031 Single press: hold the key at r1/c1 for 5 frames -> exactly one key_valid pulse with key_code = 5 after 2 frame ends; key_held rises with the pulse.
REQ-032 Bounce: toggle the key at r0/c2 every 6 clocks, then hold it steady -> no key_valid during bouncing; exactly one pulse with key_code = 3 after 2 steady frames.
REQ-033 Multi-key: press r3/c0 and r3/c2 together -> no key_valid; key_held stays 0.
REQ-034 Release: after key 0 (r3/c1) is accepted, release it -> key_held falls after 2 NONE frames; key_code stays 0; a re-press gives a new pulse.
REQ-035 Reset in PRESSED: assert rst while key 9 is held -> key_held = 0 immediately; keep 9 pressed -> one new key_valid pulse with key_code = 9 after 2 frames.

Source files
------------

// File: rtl/doorlock_pkg.sv
// doorlock_pkg
//   Shared definitions for the door-lock keypad front end.
//   - KEY_STAR / KEY_HASH : codes reported for the '*' and '#' keys
//   - scan_state_e        : keypad debounce FSM states
//   - frame_class_e       : what one complete scan frame contained
//   - key_code_of()       : (row, column) position -> reported key code
package doorlock_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_class_e;

  // Rows 0..2 form the 1..9 block laid out row-major; the bottom row
  // carries '*', '0' and '#'.
  function automatic logic [3:0] key_code_of(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    if (r == 2'd3) begin
      case (c)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync
//   Two-flop synchronizer for the four asynchronous keypad row lines.
//   Ports:
//     clk  : system clock
//     rst  : synchronous active-high reset, clears both stages
//     d    : raw row lines
//     q    : row lines retimed into the clk domain
module keypad_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
//   Scans a 4x3 matrix keypad, debounces whole scan frames and reports
//   accepted keys.
//   Parameters:
//     SCAN_DIV        : clocks each column is driven (>= 4)
//     DEBOUNCE_FRAMES : identical frames needed for a press or a release (>= 1)
//   Ports:
//     clk       : system clock
//     rst       : synchronous active-high reset
//     row       : row return lines, 1 = pressed in the driven column
//     col       : one-hot column drive
//     key_code  : code of the last accepted key
//     key_valid : one-clock pulse on acceptance
//     key_held  : high from acceptance until the release is debounced
module keypad_scan
  import doorlock_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [2:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0] row_sync;

  keypad_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (row_sync)
  );

  // Scan datapath state
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       col_q, col_d;
  logic [3:0]       rows_c0_q, rows_c0_d;
  logic [3:0]       rows_c1_q, rows_c1_d;

  // FSM state and registered outputs
  scan_state_e      state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  logic             col_end;
  logic             frame_end;
  logic [2:0][3:0]  frame_rows;
  logic [1:0]       hit_count;
  logic [3:0]       hit_code;
  frame_class_e     frame_class;
  logic [CNT_W-1:0] count_inc;

  assign col_end   = (div_q == DIV_MAX);
  assign frame_end = col_end & col_q[2];

  // Prescaler and column rotation. Rows for the first two columns are
  // parked here; the third column's rows are used live at frame end.
  always_comb begin
    div_d     = col_end ? '0 : div_q + DIV_W'(1);
    col_d     = col_end ? {col_q[1:0], col_q[2]} : col_q;
    rows_c0_d = (col_end && col_q[0]) ? row_sync : rows_c0_q;
    rows_c1_d = (col_end && col_q[1]) ? row_sync : rows_c1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      col_q     <= 3'b001;
      rows_c0_q <= '0;
      rows_c1_q <= '0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      rows_c0_q <= rows_c0_d;
      rows_c1_q <= rows_c1_d;
    end
  end

  // Frame classification; hit_count saturates at 2 since only
  // "none / one / several" matters.
  always_comb begin
    frame_rows[0] = rows_c0_q;
    frame_rows[1] = rows_c1_q;
    frame_rows[2] = row_sync;
    hit_count     = 2'd0;
    hit_code      = 4'd0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (frame_rows[c][r]) begin
          if (hit_count != 2'd2) hit_count = hit_count + 2'd1;
          hit_code = key_code_of(2'(r), 2'(c));
        end
      end
    end
    case (hit_count)
      2'd0:    frame_class = FRAME_NONE;
      2'd1:    frame_class = FRAME_SINGLE;
      default: frame_class = FRAME_MULTI;
    endcase
  end

  assign count_inc = (count_q >= CNT_MAX) ? count_q : count_q + CNT_ONE;

  // Debounce FSM, evaluated once per frame. Acceptance and release are
  // resolved after the per-state step so that DEBOUNCE_FRAMES = 1 takes
  // effect on the very first qualifying frame.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    count_d     = count_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_class == FRAME_SINGLE) begin
            cand_d  = hit_code;
            count_d = CNT_ONE;
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (frame_class == FRAME_SINGLE) begin
            if (hit_code == cand_q) begin
              count_d = count_inc;
            end else begin
              cand_d  = hit_code;
              count_d = CNT_ONE;
            end
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (frame_class == FRAME_NONE) begin
            count_d = CNT_ONE;
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (frame_class == FRAME_NONE) begin
            count_d = count_inc;
          end else begin
            count_d = '0;
            state_d = PRESSED;
          end
        end
        default: begin
          count_d = '0;
          state_d = IDLE;
        end
      endcase
      if (state_d == DEBOUNCE && count_d >= CNT_MAX) begin
        key_code_d  = cand_d;
        key_valid_d = 1'b1;
        key_held_d  = 1'b1;
        count_d     = '0;
        state_d     = PRESSED;
      end else if (state_d == RELEASE && count_d >= CNT_MAX) begin
        key_held_d = 1'b0;
        count_d    = '0;
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      count_q     <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      count_q     <= count_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
//   Drives a modelled 4x3 keypad into keypad_scan (SCAN_DIV = 4,
//   DEBOUNCE_FRAMES = 2) and compares every clock against a frame-level
//   reference model, plus directed end-of-scenario checks.
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DF       = 2;
  localparam int FRAME    = 3 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [2:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  // Pressed-key map, bit index = row*3 + column
  logic [11:0] keys = '0;

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference model state
  int          n = 0;
  logic [11:0] hist [4];
  logic [11:0] frame_keys = '0;
  int          run_key = 0;
  int          run_len = 0;
  int          rel_len = 0;
  bit          exp_valid = 1'b0;
  bit          exp_held  = 1'b0;
  int          exp_code  = 0;
  int          code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};

  int dut_pulses   = 0;
  int model_pulses = 0;

  always #5 clk = ~clk;

  // Keypad matrix: a pressed key connects its column drive to its row line
  always_comb begin
    row = '0;
    for (int r = 0; r < 4; r++) begin
      row[r] = (col[0] & keys[r*3]) | (col[1] & keys[r*3+1]) | (col[2] & keys[r*3+2]);
    end
  end

  keypad_scan #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_FRAMES (DF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    if (observed !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] k, input int cycles);
    keys = k;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // One whole frame judged from the rules: none / one / many keys seen,
  // then press and release acceptance by runs of identical frames.
  task automatic evaluateFrame();
    int cnt;
    int code;
    cnt  = $countones(frame_keys);
    code = -1;
    for (int i = 0; i < 12; i++) if (frame_keys[i]) code = code_tab[i];
    if (!exp_held) begin
      if (cnt == 1) begin
        if (run_len > 0 && code == run_key) run_len++;
        else begin
          run_key = code;
          run_len = 1;
        end
        if (run_len >= DF) begin
          exp_valid = 1'b1;
          exp_held  = 1'b1;
          exp_code  = code;
          run_len   = 0;
          rel_len   = 0;
        end
      end else begin
        run_len = 0;
      end
    end else begin
      if (cnt == 0) begin
        rel_len++;
        if (rel_len >= DF) begin
          exp_held = 1'b0;
          rel_len  = 0;
        end
      end else begin
        rel_len = 0;
      end
    end
  endtask

  // Model: n counts clocks since reset release. A column is sampled on
  // the clock ending its period and sees the keypad as it was two clocks
  // earlier (synchronizer depth); column 2's sample closes the frame.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        n          = 0;
        exp_valid  = 1'b0;
        exp_held   = 1'b0;
        exp_code   = 0;
        run_len    = 0;
        rel_len    = 0;
        frame_keys = '0;
      end else begin
        int c;
        logic [11:0] seen;
        n++;
        exp_valid = 1'b0;
        hist[n % 4] = keys;
        if (n % SCAN_DIV == 0) begin
          c    = ((n - 1) / SCAN_DIV) % 3;
          seen = hist[(n - 2) % 4];
          for (int r = 0; r < 4; r++) frame_keys[r*3+c] = seen[r*3+c];
          if (c == 2) evaluateFrame();
        end
      end
    end
  end

  // Per-clock comparison against the model, away from the active edge
  initial begin
    forever begin
      logic [2:0] exp_col;
      @(negedge clk);
      exp_col = 3'(3'b001 << ((n / SCAN_DIV) % 3));
      checkOutput("col", 32'(col), 32'(exp_col));
      checkOutput("key_valid", 32'(key_valid), 32'(exp_valid));
      checkOutput("key_held", 32'(key_held), 32'(exp_held));
      checkOutput("key_code", 32'(key_code), 32'(exp_code));
      if (key_valid === 1'b1) dut_pulses++;
      if (exp_valid) model_pulses++;
    end
  end

  initial begin
    logic [11:0] k;
    int          sel;
    int          total_dut;
    int          total_model;
    total_dut   = 0;
    total_model = 0;

    // Reset values and first column step
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_col", 32'(col), 32'(3'b001));
    checkOutput("rst_code", 32'(key_code), 32'd0);
    checkOutput("rst_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_held", 32'(key_held), 32'd0);
    applyStimulus('0, 4);
    checkOutput("col_step", 32'(col), 32'(3'b010));

    // Single press of '5' (r1/c1)
    dut_pulses = 0;
    applyStimulus(12'(1 << 4), 5 * FRAME);
    checkOutput("s5_pulses", 32'(dut_pulses), 32'd1);
    checkOutput("s5_code", 32'(key_code), 32'd5);
    checkOutput("s5_held", 32'(key_held), 32'd1);
    applyStimulus('0, 4 * FRAME);
    checkOutput("s5_released", 32'(key_held), 32'd0);
    total_dut += dut_pulses;

    // Bouncing '3' (r0/c2), toggling every 6 clocks, then steady
    for (int i = 0; i < FRAME && (n % FRAME) != 0; i++) applyStimulus('0, 1);
    dut_pulses = 0;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? 12'(1 << 2) : 12'd0, 6);
    checkOutput("bounce_pulses", 32'(dut_pulses), 32'd0);
    applyStimulus(12'(1 << 2), 4 * FRAME);
    checkOutput("steady3_pulses", 32'(dut_pulses), 32'd1);
    checkOutput("steady3_code", 32'(key_code), 32'd3);
    applyStimulus('0, 4 * FRAME);
    total_dut += dut_pulses;

    // '*' and '#' together
    dut_pulses = 0;
    applyStimulus(12'((1 << 9) | (1 << 11)), 4 * FRAME);
    checkOutput("multi_pulses", 32'(dut_pulses), 32'd0);
    checkOutput("multi_held", 32'(key_held), 32'd0);
    applyStimulus('0, 2 * FRAME);

    // '0' (r3/c1): accept, release, re-press
    dut_pulses = 0;
    applyStimulus(12'(1 << 10), 4 * FRAME);
    checkOutput("k0_pulses", 32'(dut_pulses), 32'd1);
    checkOutput("k0_code", 32'(key_code), 32'd0);
    checkOutput("k0_held", 32'(key_held), 32'd1);
    applyStimulus('0, 4 * FRAME);
    checkOutput("k0_release_held", 32'(key_held), 32'd0);
    checkOutput("k0_release_code", 32'(key_code), 32'd0);
    applyStimulus(12'(1 << 10), 4 * FRAME);
    checkOutput("k0_repress_pulses", 32'(dut_pulses), 32'd2);
    applyStimulus('0, 4 * FRAME);
    total_dut += dut_pulses;

    // Reset while '9' (r2/c2) is held
    dut_pulses = 0;
    applyStimulus(12'(1 << 8), 4 * FRAME);
    checkOutput("k9_held", 32'(key_held), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("k9_rst_held", 32'(key_held), 32'd0);
    checkOutput("k9_rst_valid", 32'(key_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    total_dut += dut_pulses;
    dut_pulses = 0;
    applyStimulus(12'(1 << 8), 4 * FRAME);
    checkOutput("k9_after_rst_pulses", 32'(dut_pulses), 32'd1);
    checkOutput("k9_after_rst_code", 32'(key_code), 32'd9);
    applyStimulus('0, 4 * FRAME);
    total_dut += dut_pulses;

    // Random key patterns of random length, occasionally with reset
    dut_pulses   = 0;
    model_pulses = 0;
    for (int it = 0; it < 30; it++) begin
      sel = int'($urandom_range(0, 3));
      k   = '0;
      if (sel == 1 || sel == 2) k[$urandom_range(0, 11)] = 1'b1;
      if (sel == 3) begin
        k[$urandom_range(0, 11)] = 1'b1;
        k[$urandom_range(0, 11)] = 1'b1;
      end
      applyStimulus(k, int'($urandom_range(1, 40)));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end
    applyStimulus('0, 4 * FRAME);
    checkOutput("rand_pulses", 32'(dut_pulses), 32'(model_pulses));
    checkOutput("final_held", 32'(key_held), 32'd0);
    total_dut += dut_pulses;
    $display("[TB] directed+random key_valid pulses seen: %0d", total_dut);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
